pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//   Produces the pc_selector / jmp_pc pair consumed by the IF-stage PC mux.
//   Sits at the end of EX. Resolves branches and jumps from EX-stage flags and
//   operands, then issues a one-shot redirect to fetch. Squashes wrong-path
//   instructions in IF/ID with a bounded flush sequence.
// PARAMETERS
//   N            32  PC / operand width in bits
//   FLUSH_CYCLES 2   cycles flush_o is held after a redirect (>=1)
// PORTS
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous, active-low reset
//   stall_i      in   1  pipeline stall; freezes FSM, counter and all outputs
//   ex_valid_i   in   1  EX holds a valid instruction this cycle
//   ex_branch_i  in   1  EX instruction is a conditional branch
//   ex_jump_i    in   1  EX instruction is an unconditional jump (register target)
//   br_type_i    in   2  00 BEQ, 01 BNE, 10 BLT, 11 BGE
//   zero_i       in   1  ALU zero flag of the compare
//   neg_i        in   1  ALU negative flag of the compare (signed)
//   ex_pc_i      in   N  PC of the EX instruction
//   ex_imm_i     in   N  sign-extended word offset (branch) or absolute target (jump)
//   pc_selector  out  1  1 = fetch takes jmp_pc, 0 = sequential pc
//   jmp_pc       out  N  redirect target
//   flush_o      out  1  squash IF/ID contents
//   busy_o       out  1  FSM not in IDLE
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, pc_selector=0, jmp_pc=0, flush_o=0,
//     busy_o=0, flush counter=0. Reset mid-redirect or mid-flush aborts it
//     immediately.
//   Taken condition: BEQ zero_i; BNE !zero_i; BLT neg_i; BGE !neg_i.
//   take = ex_valid_i & (ex_jump_i | (ex_branch_i & cond)).
//     ex_jump_i has priority over ex_branch_i when both are set.
//   Target: jump -> ex_imm_i. Branch -> ex_pc_i + (ex_imm_i << 2),
//     truncated to N bits (wraps mod 2^N). Bits [1:0] of the target are
//     forced to 0.
//   FSM, all transitions on the rising clk edge, only when stall_i=0:
//     IDLE:     take=1 -> REDIRECT; register jmp_pc; pc_selector=1 next cycle.
//               take=0 -> stay in IDLE; pc_selector=0.
//     REDIRECT: exactly one cycle, pc_selector=1, flush_o=1.
//               -> FLUSH with counter=FLUSH_CYCLES-1.
//               If FLUSH_CYCLES=1 -> IDLE instead.
//     FLUSH:    pc_selector=0, flush_o=1, counter decrements each cycle.
//               counter==0 -> IDLE.
//               take is ignored in FLUSH: EX holds wrong-path instructions.
//   Latency: resolution in EX cycle t -> pc_selector=1 and flush_o=1 in t+1.
//     flush_o is high for FLUSH_CYCLES consecutive unstalled cycles.
//   Stall: stall_i=1 holds state, counter, jmp_pc, pc_selector and flush_o
//     unchanged. A redirect held under stall stays asserted until the first
//     unstalled cycle consumes it. take sampled while stalled in IDLE is
//     ignored; EX re-presents the instruction after the stall.
//   Registered outputs only; no combinational path from any input to any output.
//   jmp_pc holds its last value when pc_selector=0.
//   busy_o = (state != IDLE).
// TESTING
//   BEQ, zero_i=1, ex_pc_i=0x100, ex_imm_i=0x4 -> next cycle pc_selector=1,
//     jmp_pc=0x110; flush_o high 2 cycles; busy_o clears on the 3rd cycle.
//   BNE, zero_i=1 -> pc_selector and flush_o stay 0, state stays IDLE.
//   Jump and branch set together, ex_imm_i=0x2003 -> jmp_pc=0x2000
//     (jump priority, low bits cleared).
//   ex_pc_i=0xFFFFFFFC, ex_imm_i=0x2 -> jmp_pc=0x00000004 (wrap-around).
//   stall_i=1 for 3 cycles during REDIRECT -> pc_selector held 1 for 4 cycles
//     total, then FLUSH proceeds. A second taken branch during FLUSH is
//     ignored.
//   rst_n pulsed low during FLUSH -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/pc_redirect_unit_if.sv
// Bundle between the EX stage / IF PC mux and pc_redirect_unit.
// master: EX/fetch side (drives EX flags, consumes redirect); slave: the unit.
interface pc_redirect_unit_if #(
   parameter int N = 32
);
   logic         stall_i;
   logic         ex_valid_i;
   logic         ex_branch_i;
   logic         ex_jump_i;
   logic [1:0]   br_type_i;
   logic         zero_i;
   logic         neg_i;
   logic [N-1:0] ex_pc_i;
   logic [N-1:0] ex_imm_i;
   logic         pc_selector;
   logic [N-1:0] jmp_pc;
   logic         flush_o;
   logic         busy_o;

   modport master (
      output stall_i, ex_valid_i, ex_branch_i, ex_jump_i,
      output br_type_i, zero_i, neg_i, ex_pc_i, ex_imm_i,
      input  pc_selector, jmp_pc, flush_o, busy_o
   );

   modport slave (
      input  stall_i, ex_valid_i, ex_branch_i, ex_jump_i,
      input  br_type_i, zero_i, neg_i, ex_pc_i, ex_imm_i,
      output pc_selector, jmp_pc, flush_o, busy_o
   );
endinterface

// File: rtl/pc_redirect_unit.sv
// Resolves EX branches/jumps into a one-shot registered redirect plus flush.
// Ports: clk, rst_n (async low); bus (slave): EX flags/operands in, pc_selector/jmp_pc/flush_o/busy_o out.
module pc_redirect_unit #(
   parameter int N            = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input logic              clk,
   input logic              rst_n,
   pc_redirect_unit_if.slave bus
);
   localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      FLUSH    = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   jmp_q, jmp_d;
   logic           sel_q, sel_d;
   logic           flush_q, flush_d;

   logic           cond;
   logic           take;
   logic [N-1:0]   br_tgt;
   logic [N-1:0]   tgt;

   always_comb begin
      cond = 1'b0;
      unique case (bus.br_type_i)
         2'b00: cond = bus.zero_i;
         2'b01: cond = ~bus.zero_i;
         2'b10: cond = bus.neg_i;
         2'b11: cond = ~bus.neg_i;
         default: cond = 1'b0;
      endcase
   end

   assign take = bus.ex_valid_i &
                 (bus.ex_jump_i | (bus.ex_branch_i & cond));

   // Word offset scaled to bytes; sum wraps naturally at N bits.
   assign br_tgt = bus.ex_pc_i + (bus.ex_imm_i << 2);

   always_comb begin
      tgt      = bus.ex_jump_i ? bus.ex_imm_i : br_tgt;
      tgt[1:0] = 2'b00;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      jmp_d   = jmp_q;
      sel_d   = sel_q;
      flush_d = flush_q;
      if (!bus.stall_i) begin
         unique case (state_q)
            IDLE: begin
               sel_d   = 1'b0;
               flush_d = 1'b0;
               if (take) begin
                  state_d = REDIRECT;
                  jmp_d   = tgt;
                  sel_d   = 1'b1;
                  flush_d = 1'b1;
               end
            end
            REDIRECT: begin
               sel_d = 1'b0;
               if (FLUSH_CYCLES == 1) begin
                  state_d = IDLE;
                  flush_d = 1'b0;
                  cnt_d   = '0;
               end else begin
                  state_d = FLUSH;
                  flush_d = 1'b1;
                  cnt_d   = CW'(FLUSH_CYCLES - 1);
               end
            end
            FLUSH: begin
               // EX holds wrong-path work here, so take is ignored.
               sel_d = 1'b0;
               cnt_d = cnt_q - CW'(1);
               if (cnt_q <= CW'(1)) begin
                  state_d = IDLE;
                  flush_d = 1'b0;
                  cnt_d   = '0;
               end else begin
                  flush_d = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               sel_d   = 1'b0;
               flush_d = 1'b0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         jmp_q   <= '0;
         sel_q   <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         jmp_q   <= jmp_d;
         sel_q   <= sel_d;
         flush_q <= flush_d;
      end
   end

   assign bus.pc_selector = sel_q;
   assign bus.jmp_pc      = jmp_q;
   assign bus.flush_o     = flush_q;
   assign bus.busy_o      = (state_q != IDLE);
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit.
// Drives EX flags through the interface, checks outputs 1ns after each edge.
module tb_pc_redirect_unit;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   pc_redirect_unit_if #(.N(32)) bus ();

   pc_redirect_unit #(.N(32), .FLUSH_CYCLES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic outs(input string tag, input logic sel,
                       input logic [31:0] pc, input logic fl,
                       input logic bz);
      chk({tag, "_sel"}, 32'(bus.pc_selector), 32'(sel));
      chk({tag, "_pc"}, bus.jmp_pc, pc);
      chk({tag, "_flush"}, 32'(bus.flush_o), 32'(fl));
      chk({tag, "_busy"}, 32'(bus.busy_o), 32'(bz));
   endtask

   task automatic ex(input logic v, input logic br, input logic jp,
                     input logic [1:0] t, input logic z, input logic n,
                     input logic [31:0] pc, input logic [31:0] imm);
      bus.ex_valid_i  = v;
      bus.ex_branch_i = br;
      bus.ex_jump_i   = jp;
      bus.br_type_i   = t;
      bus.zero_i      = z;
      bus.neg_i       = n;
      bus.ex_pc_i     = pc;
      bus.ex_imm_i    = imm;
   endtask

   task automatic idle_ex();
      ex(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      bus.stall_i = 1'b0;
      idle_ex();
      #3;
      outs("reset", 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      outs("post_reset", 1'b0, 32'h0, 1'b0, 1'b0);

      // BEQ taken: 0x100 + (4<<2) = 0x110
      ex(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h100, 32'h4);
      tick();
      idle_ex();
      outs("beq_t1", 1'b1, 32'h110, 1'b1, 1'b1);
      tick();
      outs("beq_t2", 1'b0, 32'h110, 1'b1, 1'b1);
      tick();
      outs("beq_t3", 1'b0, 32'h110, 1'b0, 1'b0);

      // BNE with zero set: not taken
      ex(1'b1, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 32'h500, 32'h8);
      tick();
      idle_ex();
      outs("bne_nt", 1'b0, 32'h110, 1'b0, 1'b0);

      // Invalid EX slot never redirects
      ex(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h40);
      tick();
      idle_ex();
      outs("invalid", 1'b0, 32'h110, 1'b0, 1'b0);

      // Jump + failing branch: jump wins, low bits cleared
      ex(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h700, 32'h2003);
      tick();
      idle_ex();
      outs("jmp_prio", 1'b1, 32'h2000, 1'b1, 1'b1);
      tick();
      tick();
      outs("jmp_done", 1'b0, 32'h2000, 1'b0, 1'b0);

      // BLT taken with wrap: 0xFFFFFFFC + 8 = 0x4
      ex(1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h2);
      tick();
      idle_ex();
      outs("wrap", 1'b1, 32'h4, 1'b1, 1'b1);
      tick();
      tick();

      // BGE taken: 0x200 + (0x10<<2) = 0x240, then stall in REDIRECT
      ex(1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h200, 32'h10);
      tick();
      outs("stall_r0", 1'b1, 32'h240, 1'b1, 1'b1);
      bus.stall_i = 1'b1;
      ex(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h900, 32'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         outs($sformatf("stall_r%0d", i + 1), 1'b1, 32'h240, 1'b1, 1'b1);
      end
      bus.stall_i = 1'b0;
      idle_ex();
      tick();
      outs("stall_fl", 1'b0, 32'h240, 1'b1, 1'b1);

      // Taken branch presented in FLUSH is ignored
      ex(1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h300, 32'h1);
      tick();
      outs("fl_ignore", 1'b0, 32'h240, 1'b0, 1'b0);
      idle_ex();
      tick();
      outs("fl_ignore2", 1'b0, 32'h240, 1'b0, 1'b0);

      // Taken branch under stall in IDLE is ignored
      bus.stall_i = 1'b1;
      ex(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h1234);
      tick();
      outs("idle_stall", 1'b0, 32'h240, 1'b0, 1'b0);
      bus.stall_i = 1'b0;
      tick();
      idle_ex();
      outs("idle_resume", 1'b1, 32'h1234, 1'b1, 1'b1);
      tick();
      outs("idle_res_fl", 1'b0, 32'h1234, 1'b1, 1'b1);
      tick();

      // Async reset in FLUSH
      ex(1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0, 32'h8000);
      tick();
      idle_ex();
      tick();
      outs("pre_rst", 1'b0, 32'h8000, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      outs("async_rst", 1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      outs("after_rst", 1'b0, 32'h0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
